alu_cc_stage: RTL and testbench
===============================

# alu_cc_stage

Registered Y86-64 execute-stage ALU with condition-code register. It sits directly downstream of the decode/register-read stage and wraps the 64-bit add/subtract datapath together with AND and XOR. Each result is registered behind a valid/ready handshake. It holds ZF/SF/OF and evaluates the jXX/cmovXX condition for the instruction being accepted.

## Interface
- WIDTH, 64, datapath width; the flag rules below use bit WIDTH-1 as the sign.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has an operation.
- in_ready  output  1  stage can accept this cycle.
- alu_fun  input  4  0 = ADD, 1 = SUB, 2 = AND, 3 = XOR; 4–15 reserved.
- alu_a  input  WIDTH  operand A (valA/valC).
- alu_b  input  WIDTH  operand B (valB).
- set_cc  input  1  update CC with this operation's flags (OPq only).
- cond_fun  input  4  condition for cnd evaluation.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- val_e  output  WIDTH  registered result.
- cnd  output  1  registered condition outcome.
- zf, sf, of  output  1 each  current condition codes.

## Operation
- Accept when in_valid && in_ready. in_ready = !out_valid || out_ready, which is combinational from out_ready.
- The operation is always B op A:
  - ADD: val_e = alu_b + alu_a.
  - SUB: val_e = alu_b − alu_a.
  - AND: val_e = alu_b & alu_a.
  - XOR: val_e = alu_b ^ alu_a.
- Arithmetic wraps modulo 2^WIDTH. There is no carry output.
- Flags computed for the operation:
  - ZF = (result == 0).
  - SF = result[WIDTH-1].
  - OF for ADD = (a[msb] == b[msb]) && (r[msb] != b[msb]).
  - OF for SUB = (a[msb] != b[msb]) && (r[msb] != b[msb]).
  - OF for AND/XOR = 0.
- Reserved alu_fun: val_e = 0 and CC is never updated, even with set_cc = 1.
- cnd is evaluated from the CC value held *before* the accepting edge. The same instruction's set_cc therefore does not affect its own cnd.
- cond_fun mapping:
  - 0 → 1
  - 1 (le) → (SF^OF)|ZF
  - 2 (l) → SF^OF
  - 3 (e) → ZF
  - 4 (ne) → !ZF
  - 5 (ge) → !(SF^OF)
  - 6 (g) → !(SF^OF) && !ZF
  - 7–15 → 0
- On accept, at the same edge: val_e and cnd are loaded, out_valid is set, and CC is loaded if set_cc is high and alu_fun ≤ 3.
- If out_valid && out_ready && no accept: out_valid clears. val_e and cnd hold their last values.
- Simultaneous consume and accept: out_valid stays 1 and the new result replaces the old one. This gives a 1-per-cycle throughput.
- Backpressure (out_valid && !out_ready): in_ready = 0, and val_e, cnd and CC are frozen.

## Timing
- Latency: 1 cycle. A result accepted at edge N is visible after edge N with out_valid = 1.
- CC update takes effect after the accepting edge. The next accepted instruction sees the new CC.
- Reset values (asynchronous, immediate on rst):
  - out_valid = 0, val_e = 0, cnd = 0.
  - ZF = 1, SF = 0, OF = 0.
  - in_ready = 1 once rst is deasserted.
- Reset mid-operation discards the pending result. No accept occurs while rst is high.
- No combinational path from the in_* inputs to any output except in_ready's dependency on out_ready.

## Configuration
- COND_EVAL_EN defined: the condition evaluator is built and cnd behaves as above.
- COND_EVAL_EN undefined:
  - The evaluator is removed and cnd is registered as constant 1 on every accept.
  - cond_fun is ignored.
  - CC, val_e and the handshake are unchanged.

## Test plan
- ADD: a=2811, b=1012, set_cc=1 → val_e=3823, ZF=0, SF=0, OF=0 one cycle after accept.
- ADD overflow: a=1, b=0x7FFF_FFFF_FFFF_FFFF, set_cc=1 → val_e=0x8000_0000_0000_0000, SF=1, OF=1, ZF=0. A following op with cond_fun=2 (l) → cnd=0, since SF^OF = 0.
- SUB equal: a=b=1234, set_cc=1 → val_e=0, ZF=1. Next op with cond_fun=3 → cnd=1. Same-cycle cnd uses the old CC: load CC to ZF=0 first, then issue SUB equal with cond_fun=3 → that op's cnd=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, val_e, CC and out_valid frozen.
  - Release → one transfer per cycle and no result lost.
- Reserved alu_fun=9, set_cc=1 → val_e=0, CC unchanged.
- Assert rst while out_valid=1 → out_valid=0, val_e=0, ZF=1, SF=0, OF=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/alu_cc_stage.sv
// Registered Y86-64 execute-stage ALU (B op A) with ZF/SF/OF condition codes and jXX/cmovXX evaluation.
// Define COND_EVAL_EN to build the condition evaluator; otherwise cnd is registered as 1 on every accept.
module alu_cc_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             set_cc,
  input  logic [3:0]       cond_fun,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val_e,
  output logic             cnd,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int MSB = WIDTH - 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] val_e_q, val_e_d;
  logic             cnd_q, cnd_d;
  logic             zf_q, sf_q, of_q;
  logic             ovf_d, fun_ok_d, accept;
  logic [WIDTH-1:0] sum, diff;

  function automatic logic cond_eval(input logic [3:0] f, input logic z, input logic s,
                                     input logic o);
    case (f)
      4'd0:    return 1'b1;
      4'd1:    return (s ^ o) | z;
      4'd2:    return s ^ o;
      4'd3:    return z;
      4'd4:    return !z;
      4'd5:    return !(s ^ o);
      4'd6:    return !(s ^ o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  assign sum  = alu_b + alu_a;
  assign diff = alu_b - alu_a;

  // No accept while reset is held; otherwise free when empty or being drained.
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    val_e_d  = '0;
    ovf_d    = 1'b0;
    fun_ok_d = 1'b1;
    case (alu_fun)
      4'd0: begin
        val_e_d = sum;
        ovf_d   = (alu_a[MSB] == alu_b[MSB]) && (sum[MSB] != alu_b[MSB]);
      end
      4'd1: begin
        val_e_d = diff;
        ovf_d   = (alu_a[MSB] != alu_b[MSB]) && (diff[MSB] != alu_b[MSB]);
      end
      4'd2:    val_e_d = alu_b & alu_a;
      4'd3:    val_e_d = alu_b ^ alu_a;
      default: fun_ok_d = 1'b0;
    endcase
  end

`ifdef COND_EVAL_EN
  // Evaluated against the CC held before this edge, never this op's own flags.
  assign cnd_d = cond_eval(cond_fun, zf_q, sf_q, of_q);
`else
  logic unused_cond;
  assign unused_cond = ^{cond_fun, cond_eval(4'd0, 1'b0, 1'b0, 1'b0)};
  assign cnd_d       = 1'b1;
`endif

  assign out_valid_d = accept || (out_valid_q && !out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      val_e_q     <= '0;
      cnd_q       <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        val_e_q <= val_e_d;
        cnd_q   <= cnd_d;
        if (set_cc && fun_ok_d) begin
          zf_q <= (val_e_d == '0);
          sf_q <= val_e_d[MSB];
          of_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign val_e     = val_e_q;
  assign cnd       = cnd_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;

endmodule

// File: tb/tb_alu_cc_stage.sv
// Directed self-checking bench for alu_cc_stage; expected values are hand-computed constants.
module tb_alu_cc_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  alu_fun, cond_fun;
  logic [63:0] alu_a, alu_b, val_e;
  logic        set_cc, out_valid, out_ready, cnd, zf, sf, of;

  int checks = 0;
  int errors = 0;

  alu_cc_stage #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_fun(alu_fun), .alu_a(alu_a), .alu_b(alu_b), .set_cc(set_cc),
    .cond_fun(cond_fun), .out_valid(out_valid), .out_ready(out_ready),
    .val_e(val_e), .cnd(cnd), .zf(zf), .sf(sf), .of(of)
  );

  always #5 clk = ~clk;

  function automatic logic exp_cnd(input logic v);
`ifdef COND_EVAL_EN
    return v;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cc(input string tag, input logic z, input logic s, input logic o);
    chk({tag, ".zf"}, {63'd0, zf}, {63'd0, z});
    chk({tag, ".sf"}, {63'd0, sf}, {63'd0, s});
    chk({tag, ".of"}, {63'd0, of}, {63'd0, o});
  endtask

  task automatic issue(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic sc, input logic [3:0] cf);
    in_valid = 1'b1;
    alu_fun  = f;
    alu_a    = a;
    alu_b    = b;
    set_cc   = sc;
    cond_fun = cf;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_fun = 4'd0; alu_a = '0; alu_b = '0; set_cc = 1'b0; cond_fun = 4'd0;
    #1;
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.val_e", val_e, 64'd0);
    chk("rst.cnd", {63'd0, cnd}, 64'd0);
    chk_cc("rst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.in_ready_after", {63'd0, in_ready}, 64'd1);

    issue(4'd0, 64'd2811, 64'd1012, 1'b1, 4'd0);
    chk("add.val_e", val_e, 64'd3823);
    chk("add.out_valid", {63'd0, out_valid}, 64'd1);
    chk("add.cnd", {63'd0, cnd}, 64'd1);
    chk_cc("add", 1'b0, 1'b0, 1'b0);

    issue(4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
    chk("addovf.val_e", val_e, 64'h8000_0000_0000_0000);
    chk_cc("addovf", 1'b0, 1'b1, 1'b1);

    issue(4'd3, 64'd5, 64'd5, 1'b0, 4'd2);
    chk("xor_l.val_e", val_e, 64'd0);
    chk("xor_l.cnd", {63'd0, cnd}, {63'd0, exp_cnd(1'b0)});
    chk_cc("xor_nocc", 1'b0, 1'b1, 1'b1);

    // ZF is 0 here, so this SUB's own cnd (e) must see the old ZF.
    issue(4'd1, 64'd1234, 64'd1234, 1'b1, 4'd3);
    chk("subeq.val_e", val_e, 64'd0);
    chk("subeq.cnd_oldcc", {63'd0, cnd}, {63'd0, exp_cnd(1'b0)});
    chk_cc("subeq", 1'b1, 1'b0, 1'b0);

    issue(4'd0, 64'd1, 64'd2, 1'b0, 4'd3);
    chk("after_subeq.val_e", val_e, 64'd3);
    chk("after_subeq.cnd_e", {63'd0, cnd}, {63'd0, exp_cnd(1'b1)});

    issue(4'd1, 64'd5, 64'd3, 1'b1, 4'd4);
    chk("subneg.val_e", val_e, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("subneg.cnd_ne", {63'd0, cnd}, {63'd0, exp_cnd(1'b0)});
    chk_cc("subneg", 1'b0, 1'b1, 1'b0);

    issue(4'd9, 64'd7, 64'd8, 1'b1, 4'd2);
    chk("rsvd.val_e", val_e, 64'd0);
    chk("rsvd.cnd_l", {63'd0, cnd}, {63'd0, exp_cnd(1'b1)});
    chk_cc("rsvd", 1'b0, 1'b1, 1'b0);

    issue(4'd2, 64'hF0, 64'hFF, 1'b0, 4'd1);
    chk("and.val_e", val_e, 64'hF0);
    chk("and.cnd_le", {63'd0, cnd}, {63'd0, exp_cnd(1'b1)});
    issue(4'd2, 64'hF0, 64'hFF, 1'b0, 4'd6);
    chk("and.cnd_g", {63'd0, cnd}, {63'd0, exp_cnd(1'b0)});
    issue(4'd2, 64'hF0, 64'hFF, 1'b0, 4'd5);
    chk("and.cnd_ge", {63'd0, cnd}, {63'd0, exp_cnd(1'b0)});
    issue(4'd3, 64'h0F, 64'hFF, 1'b0, 4'd7);
    chk("xor.val_e", val_e, 64'hF0);
    chk("xor.cnd_rsvd", {63'd0, cnd}, {63'd0, exp_cnd(1'b0)});

    // Backpressure: pending ADD must not be taken while out_ready is low.
    out_ready = 1'b0;
    in_valid = 1'b1; alu_fun = 4'd0; alu_a = 64'd10; alu_b = 64'd20;
    set_cc = 1'b1; cond_fun = 4'd0;
    #1;
    chk("bp.in_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp.in_ready_hold", {63'd0, in_ready}, 64'd0);
      chk("bp.out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp.val_e", val_e, 64'hF0);
      chk_cc("bp", 1'b0, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("bp.add_val_e", val_e, 64'd30);
    chk("bp.add_out_valid", {63'd0, out_valid}, 64'd1);
    chk_cc("bp.add", 1'b0, 1'b0, 1'b0);

    issue(4'd1, 64'd30, 64'd30, 1'b1, 4'd0);
    chk("stream1.val_e", val_e, 64'd0);
    chk("stream1.out_valid", {63'd0, out_valid}, 64'd1);
    chk_cc("stream1", 1'b1, 1'b0, 1'b0);
    issue(4'd0, 64'd1, 64'd2, 1'b0, 4'd0);
    chk("stream2.val_e", val_e, 64'd3);
    chk("stream2.out_valid", {63'd0, out_valid}, 64'd1);

    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain.out_valid", {63'd0, out_valid}, 64'd0);
    chk("drain.val_e_hold", val_e, 64'd3);

    // Asynchronous reset with a result pending.
    issue(4'd0, 64'd4, 64'd5, 1'b1, 4'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pre_rst.out_valid", {63'd0, out_valid}, 64'd1);
    chk("pre_rst.val_e", val_e, 64'd9);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst.val_e", val_e, 64'd0);
    chk_cc("async_rst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("post_rst.in_ready", {63'd0, in_ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
